// File: rtl/creek_exec_sequencer.sv
// Run sequencer for the creek vector core: launches a program, auto-acknowledges a
// programmed number of wait points, halts for host attention, and bounds run time.
module creek_exec_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avl_address,
    input  logic [31:0] avl_writedata,
    input  logic        avl_write,
    input  logic        avl_read,
    output logic [31:0] avl_readdata,
    output logic        pause_n,
    output logic        resume,
    input  logic        waiting,
    output logic        irq
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_RESUME  = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

    logic [2:0]  state_reg, state_next;
    logic        go_reg, abort_reg, host_resume_reg;
    logic        waiting_reg;
    logic [15:0] reload_reg;
    logic [15:0] remaining_reg, remaining_next;
    logic [31:0] timeout_reg;
    logic [31:0] wdog_reg, wdog_next;
    logic [1:0]  pend_reg;
    logic [1:0]  pend_set;
    logic        irq_en_reg;
    logic        irq_reg;
    logic [31:0] readdata_reg;

    logic        wr_ctrl, wr_auto, wr_tmo, wr_irq;
    logic        wdog_hit;
    logic [31:0] wdog_inc;

    assign wr_ctrl = avl_write && (avl_address == 2'd0);
    assign wr_auto = avl_write && (avl_address == 2'd1);
    assign wr_tmo  = avl_write && (avl_address == 2'd2);
    assign wr_irq  = avl_write && (avl_address == 2'd3);

    assign wdog_hit = (timeout_reg != 32'd0) && (wdog_reg == timeout_reg);
    assign wdog_inc = (&wdog_reg) ? wdog_reg : wdog_reg + 32'd1;

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        wdog_next      = wdog_reg;
        pend_set       = 2'b00;
        if (abort_reg) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_FAULT: begin
                    if (go_reg) begin
                        state_next     = ST_RUN;
                        remaining_next = reload_reg;
                        wdog_next      = 32'd0;
                    end
                end
                ST_RUN: begin
                    wdog_next = wdog_inc;
                    // A timeout in the same cycle as a wait point wins.
                    if (wdog_hit) begin
                        state_next  = ST_FAULT;
                        pend_set[1] = 1'b1;
                    end else if (waiting_reg) begin
                        if (remaining_reg != 16'd0) begin
                            state_next     = ST_RESUME;
                            remaining_next = remaining_reg - 16'd1;
                        end else begin
                            state_next  = ST_HALT;
                            pend_set[0] = 1'b1;
                        end
                    end
                end
                ST_RESUME: begin
                    state_next = ST_RELEASE;
                end
                ST_RELEASE: begin
                    wdog_next = wdog_inc;
                    if (wdog_hit) begin
                        state_next  = ST_FAULT;
                        pend_set[1] = 1'b1;
                    end else if (!waiting_reg) begin
                        state_next = ST_RUN;
                        wdog_next  = 32'd0;
                    end
                end
                ST_HALT: begin
                    if (host_resume_reg) begin
                        state_next = ST_RESUME;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            go_reg          <= 1'b0;
            abort_reg       <= 1'b0;
            host_resume_reg <= 1'b0;
            waiting_reg     <= 1'b0;
            reload_reg      <= 16'd0;
            remaining_reg   <= 16'd0;
            timeout_reg     <= 32'd0;
            wdog_reg        <= 32'd0;
            irq_en_reg      <= 1'b0;
            irq_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            go_reg          <= wr_ctrl & avl_writedata[0];
            abort_reg       <= wr_ctrl & avl_writedata[1];
            host_resume_reg <= wr_ctrl & avl_writedata[2];
            waiting_reg     <= waiting;
            remaining_reg   <= remaining_next;
            wdog_reg        <= wdog_next;
            irq_reg         <= irq_en_reg & (|pend_reg);
            if (wr_auto) begin
                reload_reg <= avl_writedata[15:0];
            end
            if (wr_tmo) begin
                timeout_reg <= avl_writedata;
            end
            if (wr_irq) begin
                irq_en_reg <= avl_writedata[8];
            end
        end
    end

    // Pending bits: bit0 halt, bit1 timeout; a hardware set outranks a W1C.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pend
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pend_reg[gi] <= 1'b0;
                end else if (pend_set[gi]) begin
                    pend_reg[gi] <= 1'b1;
                end else if (wr_irq && avl_writedata[gi]) begin
                    pend_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= 32'd0;
        end else if (avl_read) begin
            case (avl_address)
                2'd0:    readdata_reg <= {27'd0, irq_reg, waiting_reg, state_reg};
                2'd1:    readdata_reg <= {remaining_reg, reload_reg};
                2'd2:    readdata_reg <= timeout_reg;
                default: readdata_reg <= {23'd0, irq_en_reg, 6'd0, pend_reg};
            endcase
        end
    end

    assign avl_readdata = readdata_reg;
    assign pause_n      = (state_reg == ST_RUN) || (state_reg == ST_RESUME) ||
                          (state_reg == ST_RELEASE) || (state_reg == ST_HALT);
    assign resume       = (state_reg == ST_RESUME);
    assign irq          = irq_reg;

endmodule

// File: tb/tb_creek_exec_sequencer.sv
// Directed plus randomized bench for creek_exec_sequencer; expectations come from
// wait-point/timeout arithmetic rather than a cycle model.
module tb_creek_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avl_address = 2'd0;
    logic [31:0] avl_writedata = 32'd0;
    logic        avl_write = 1'b0;
    logic        avl_read = 1'b0;
    logic [31:0] avl_readdata;
    logic        pause_n;
    logic        resume;
    logic        waiting = 1'b0;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    creek_exec_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avl_address  (avl_address),
        .avl_writedata(avl_writedata),
        .avl_write    (avl_write),
        .avl_read     (avl_read),
        .avl_readdata (avl_readdata),
        .pause_n      (pause_n),
        .resume       (resume),
        .waiting      (waiting),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avl_address   = a;
        avl_writedata = d;
        avl_write     = 1'b1;
        tick();
        avl_write     = 1'b0;
        avl_writedata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avl_address = a;
        avl_read    = 1'b1;
        tick();
        avl_read    = 1'b0;
        d           = avl_readdata;
    endtask

    // Core raises waiting and drops it 3 cycles after the resume pulse; if no
    // pulse comes the core stays blocked with waiting high.
    task automatic core_wait(output int n_res);
        int drop_at;
        n_res   = 0;
        drop_at = -1;
        waiting = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (resume) begin
                n_res++;
                drop_at = i + 3;
            end
            if (i == drop_at) waiting = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] d;
        int n, cnt, r, w, rem, t;
        bit halted;

        // Reset state
        repeat (3) tick();
        chk("rst_pause_n", {31'd0, pause_n}, 32'd0);
        chk("rst_resume", {31'd0, resume}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_readdata", avl_readdata, 32'd0);
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            chk($sformatf("rst_reg%0d", a), d, 32'd0);
        end

        // AUTO=2: two auto-acknowledged wait points, then HALT
        wr(2'd3, 32'h100);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'd1);
        tick();
        chk("go_pause_n", {31'd0, pause_n}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            core_wait(n);
            chk($sformatf("auto2_wait%0d_pulses", j), n, (j < 2) ? 32'd1 : 32'd0);
        end
        rd(2'd0, d);
        chk("halt_ctrl", d, 32'h1C);
        rd(2'd1, d);
        chk("halt_auto", d, 32'h0000_0002);
        rd(2'd3, d);
        chk("halt_irqreg", d, 32'h101);
        chk("halt_irq_pin", {31'd0, irq}, 32'd1);

        // host_resume from HALT, then clear halt_pend
        wr(2'd0, 32'd4);
        core_wait(n);
        chk("host_resume_pulses", n, 32'd1);
        rd(2'd0, d);
        chk("host_resume_ctrl", d, 32'h11);
        wr(2'd3, 32'h101);
        tick();
        chk("w1c_irq_pin", {31'd0, irq}, 32'd0);
        rd(2'd3, d);
        chk("w1c_irqreg", d, 32'h100);

        // Randomized reload / wait-point counts
        for (int k = 0; k < 8; k++) begin
            waiting = 1'b0;
            wr(2'd0, 32'd2);
            wr(2'd3, 32'h103);
            r = $urandom_range(0, 4);
            w = $urandom_range(0, 5);
            wr(2'd1, r);
            wr(2'd0, 32'd1);
            tick();
            halted = (w > r);
            for (int j = 0; j < w; j++) begin
                core_wait(n);
                chk($sformatf("rnd%0d_r%0d_wait%0d", k, r, j), n, (j < r) ? 32'd1 : 32'd0);
                if (j >= r) break;
            end
            rem = halted ? 0 : r - w;
            rd(2'd1, d);
            chk($sformatf("rnd%0d_auto", k), d, {rem[15:0], r[15:0]});
            rd(2'd3, d);
            chk($sformatf("rnd%0d_irqreg", k), d, halted ? 32'h101 : 32'h100);
            rd(2'd0, d);
            chk($sformatf("rnd%0d_ctrl", k), d, halted ? 32'h1C : 32'h01);
        end

        // Watchdog: FAULT T+1 cycles after RUN entry
        for (int k = 0; k < 3; k++) begin
            waiting = 1'b0;
            wr(2'd0, 32'd2);
            wr(2'd3, 32'h103);
            t = (k == 0) ? 10 : $urandom_range(4, 30);
            wr(2'd2, t);
            wr(2'd0, 32'd1);
            tick();
            chk($sformatf("tmo%0d_run_pause_n", t), {31'd0, pause_n}, 32'd1);
            cnt = 0;
            while (pause_n && cnt < 100) begin
                tick();
                cnt++;
            end
            chk($sformatf("tmo%0d_cycles", t), cnt, t + 1);
            chk($sformatf("tmo%0d_irq_lag", t), {31'd0, irq}, 32'd0);
            tick();
            chk($sformatf("tmo%0d_irq", t), {31'd0, irq}, 32'd1);
            rd(2'd3, d);
            chk($sformatf("tmo%0d_irqreg", t), d, 32'h102);
            wr(2'd0, 32'd1);
            tick();
            rd(2'd0, d);
            chk($sformatf("tmo%0d_rego_ctrl", t), d, 32'h11);
        end
        wr(2'd2, 32'd0);
        wr(2'd0, 32'd2);
        wr(2'd3, 32'h103);

        // go and abort in the same write
        wr(2'd0, 32'd3);
        tick();
        chk("go_abort_pause_n", {31'd0, pause_n}, 32'd0);
        rd(2'd0, d);
        chk("go_abort_ctrl", d, 32'h0);

        // abort while in RESUME
        wr(2'd1, 32'd0);
        waiting = 1'b1;
        wr(2'd0, 32'd1);
        repeat (6) tick();
        rd(2'd0, d);
        chk("pre_abort_ctrl", d, 32'h1C);
        wr(2'd0, 32'd4);
        chk("abort_pre_resume", {31'd0, resume}, 32'd0);
        wr(2'd0, 32'd2);
        chk("abort_in_resume", {31'd0, resume}, 32'd1);
        tick();
        chk("abort_resume_cut", {31'd0, resume}, 32'd0);
        chk("abort_pause_n", {31'd0, pause_n}, 32'd0);
        rd(2'd0, d);
        chk("abort_state", {29'd0, d[2:0]}, 32'd0);
        waiting = 1'b0;

        // Async reset in RELEASE
        wr(2'd3, 32'h103);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd1);
        tick();
        waiting = 1'b1;
        cnt = 0;
        while (!resume && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("rel_resume_seen", {31'd0, resume}, 32'd1);
        tick();
        rd(2'd1, d);
        chk("rel_auto", d, 32'h0000_0001);
        tick();
        chk("readdata_hold", avl_readdata, 32'h0000_0001);
        chk("rel_pause_n", {31'd0, pause_n}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pause_n", {31'd0, pause_n}, 32'd0);
        chk("arst_resume", {31'd0, resume}, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk("arst_readdata", avl_readdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("arst_hold_resume%0d", i), {31'd0, resume}, 32'd0);
        end
        waiting = 1'b0;
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            chk($sformatf("arst_reg%0d", a), d, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
